univ_shift_reg_n: RTL and testbench

Parametrised universal shift register, successor to the team's fixed 4-bit universal shifter. Adds a generic WIDTH, rotate and arithmetic modes, and an enable. Adds a multi-step "shift by N" sequencer with a busy/done handshake so control logic can request N shifts with a single pulse. Sits in datapath/serial-conversion paths alongside the existing counters and registers.

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_step_n.sv | 29 ++
 rtl/univ_shift_reg_n.sv | 97 +++++++++
 tb/tb_univ_shift_reg_n.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared mode and state encodings for the universal shift register.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Only shift/rotate modes are worth repeating; hold/load/reserved are one-shot.
  function automatic logic is_multi_mode(input logic [2:0] m);
    return (m != MODE_HOLD) && (m != MODE_LOAD) && (m != MODE_RSVD);
  endfunction

endpackage

// File: rtl/shift_step_n.sv
// One step of the universal shifter: next register value for a given op.
module shift_step_n
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [2:0]       op,
  input  logic             sr_ser,
  input  logic             sl_ser,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] nxt
);

  // Next-value mux; hold and reserved both keep the current value.
  always_comb begin
    nxt = cur;
    case (op)
      MODE_SHR:  nxt = {sr_ser, cur[WIDTH-1:1]};
      MODE_SHL:  nxt = {cur[WIDTH-2:0], sl_ser};
      MODE_LOAD: nxt = din;
      MODE_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default:   nxt = cur;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_n.sv
// Parametrised universal shift register with a multi-step shift sequencer.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | single-step ops under en; start launches a sequence
//   ST_RUN  | applies latched op once per edge until the down-counter ends
module univ_shift_reg_n
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sr_ser,
  input  logic             sl_ser,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] dout,
  output logic             sr_out,
  output logic             sl_out,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] reg_q;
  logic             done_q;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_val;

  // The step function is shared: RUN uses the latched op, IDLE the live mode.
  assign step_op = (state == ST_RUN) ? op_q : mode;

  shift_step_n #(.WIDTH(WIDTH)) u_step (
    .cur    (reg_q),
    .op     (step_op),
    .sr_ser (sr_ser),
    .sl_ser (sl_ser),
    .din    (din),
    .nxt    (step_val)
  );

  // Register, sequencer FSM, down-counter and done pulse.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state  <= ST_IDLE;
      op_q   <= MODE_HOLD;
      count  <= '0;
      reg_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_RUN: begin
          reg_q <= step_val;
          count <= count - CNT_W'(1);
          // Terminal count: this edge applies the final step.
          if (count == CNT_W'(1)) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: begin
          if (en) begin
            if (start) begin
              if (amt == '0) begin
                done_q <= 1'b1;
              end else if (is_multi_mode(mode)) begin
                op_q  <= mode;
                count <= amt;
                state <= ST_RUN;
              end else begin
                reg_q  <= step_val;
                done_q <= 1'b1;
              end
            end else begin
              reg_q <= step_val;
            end
          end
        end
      endcase
    end
  end

  assign dout   = reg_q;
  assign sr_out = reg_q[0];
  assign sl_out = reg_q[WIDTH-1];
  assign busy   = (state == ST_RUN);
  assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Directed bench for univ_shift_reg_n at WIDTH=8.
module tb_univ_shift_reg_n;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             clk;
  logic             clr;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] din;
  logic             sr_ser;
  logic             sl_ser;
  logic             start;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] dout;
  logic             sr_out;
  logic             sl_out;
  logic             busy;
  logic             done;

  int checks;
  int failures;

  univ_shift_reg_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .clr    (clr),
    .en     (en),
    .mode   (mode),
    .din    (din),
    .sr_ser (sr_ser),
    .sl_ser (sl_ser),
    .start  (start),
    .amt    (amt),
    .dout   (dout),
    .sr_out (sr_out),
    .sl_out (sl_out),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [WIDTH-1:0] v);
    en = 1'b1; start = 1'b0; mode = 3'b011; din = v;
    tick();
    mode = 3'b000;
  endtask

  // Launch a sequence and count busy cycles until it drops (bounded).
  task automatic run_start(input logic [2:0] m, input logic [CNT_W-1:0] a,
                           output int busy_cycles);
    en = 1'b1; mode = m; amt = a; start = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000;
    busy_cycles = 0;
    while (busy && busy_cycles < 40) begin
      busy_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    tick();
    checks++;
    if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset: dout=%h busy=%b done=%b, want 00/0/0", dout, busy, done);
    end
    clr = 1'b1;
    load_val(8'hA5);
    checks++;
    if (dout !== 8'hA5) begin
      failures++;
      $display("FAIL load: dout=%h want a5", dout);
    end
    clr = 1'b0;
    tick();
    clr = 1'b1;
    checks++;
    if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_after_load: dout=%h busy=%b done=%b, want 00/0/0", dout, busy, done);
    end
  endtask

  task automatic test_single_step();
    load_val(8'hA5);
    checks++;
    if (sr_out !== 1'b1 || sl_out !== 1'b1) begin
      failures++;
      $display("FAIL serial_out_a5: sr_out=%b sl_out=%b want 1/1", sr_out, sl_out);
    end
    mode = 3'b001; sr_ser = 1'b1;
    tick();
    checks++;
    if (dout !== 8'hD2 || done !== 1'b0) begin
      failures++;
      $display("FAIL shr_step: dout=%h done=%b want d2/0", dout, done);
    end
    checks++;
    if (sr_out !== 1'b0 || sl_out !== 1'b1) begin
      failures++;
      $display("FAIL serial_out_d2: sr_out=%b sl_out=%b want 0/1", sr_out, sl_out);
    end
    mode = 3'b010; sl_ser = 1'b0;
    tick();
    checks++;
    if (dout !== 8'hA4) begin
      failures++;
      $display("FAIL shl_step: dout=%h want a4", dout);
    end
    mode = 3'b111;
    tick();
    checks++;
    if (dout !== 8'hA4) begin
      failures++;
      $display("FAIL reserved_hold: dout=%h want a4", dout);
    end
    mode = 3'b000;
  endtask

  task automatic test_rotate_seq();
    load_val(8'h81);
    en = 1'b1; mode = 3'b100; amt = 4'd3; start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL ror_busy_%0d: busy=%b done=%b want 1/0", k, busy, done);
      end
      // Garbage on control inputs while running must be ignored.
      mode = (k == 1) ? 3'b011 : 3'b010;
      din = 8'hFF;
      start = k[0];
      amt = 4'd7;
      tick();
    end
    mode = 3'b000; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || dout !== 8'h30) begin
      failures++;
      $display("FAIL ror_done: busy=%b done=%b dout=%h want 0/1/30", busy, done, dout);
    end
    tick();
    checks++;
    if (done !== 1'b0 || dout !== 8'h30) begin
      failures++;
      $display("FAIL ror_done_pulse: done=%b dout=%h want 0/30", done, dout);
    end
  endtask

  task automatic test_asr_shl();
    int bc;
    load_val(8'h80);
    run_start(3'b110, 4'd2, bc);
    checks++;
    if (bc != 2 || done !== 1'b1 || dout !== 8'hE0) begin
      failures++;
      $display("FAIL asr2: busy_cycles=%0d done=%b dout=%h want 2/1/e0", bc, done, dout);
    end
    load_val(8'hFF);
    sl_ser = 1'b0;
    run_start(3'b010, 4'd8, bc);
    checks++;
    if (bc != 8 || done !== 1'b1 || dout !== 8'h00) begin
      failures++;
      $display("FAIL shl8: busy_cycles=%0d done=%b dout=%h want 8/1/00", bc, done, dout);
    end
    load_val(8'h96);
    run_start(3'b101, 4'd8, bc);
    checks++;
    if (bc != 8 || done !== 1'b1 || dout !== 8'h96) begin
      failures++;
      $display("FAIL rol8: busy_cycles=%0d done=%b dout=%h want 8/1/96", bc, done, dout);
    end
    load_val(8'h00);
    sr_ser = 1'b1;
    run_start(3'b001, 4'd10, bc);
    checks++;
    if (bc != 10 || done !== 1'b1 || dout !== 8'hFF) begin
      failures++;
      $display("FAIL shr10: busy_cycles=%0d done=%b dout=%h want 10/1/ff", bc, done, dout);
    end
  endtask

  task automatic test_abort();
    int bc;
    int done_seen;
    load_val(8'h01);
    en = 1'b1; mode = 3'b101; amt = 4'd5; start = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000;
    tick();
    tick();
    checks++;
    if (dout !== 8'h04 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_mid: dout=%h busy=%b want 04/1", dout, busy);
    end
    clr = 1'b0;
    tick();
    clr = 1'b1;
    checks++;
    if (dout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset: dout=%h busy=%b done=%b want 00/0/0", dout, busy, done);
    end
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL abort_quiet: activity_cycles=%0d want 0", done_seen);
    end
    load_val(8'h01);
    run_start(3'b101, 4'd2, bc);
    checks++;
    if (bc != 2 || done !== 1'b1 || dout !== 8'h04) begin
      failures++;
      $display("FAIL after_abort: busy_cycles=%0d done=%b dout=%h want 2/1/04", bc, done, dout);
    end
  endtask

  task automatic test_degenerate();
    load_val(8'h3C);
    en = 1'b1; mode = 3'b001; amt = 4'd0; start = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || dout !== 8'h3C) begin
      failures++;
      $display("FAIL amt0: busy=%b done=%b dout=%h want 0/1/3c", busy, done, dout);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL amt0_after: busy=%b done=%b want 0/0", busy, done);
    end
    en = 1'b0; mode = 3'b100; amt = 4'd3; start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h3C) begin
      failures++;
      $display("FAIL en0_start: busy=%b done=%b dout=%h want 0/0/3c", busy, done, dout);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || dout !== 8'h3C) begin
      failures++;
      $display("FAIL en0_hold: busy=%b dout=%h want 0/3c", busy, dout);
    end
    en = 1'b1; mode = 3'b011; din = 8'h5A; amt = 4'd4; start = 1'b1;
    tick();
    start = 1'b0; mode = 3'b000;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || dout !== 8'h5A) begin
      failures++;
      $display("FAIL start_load: busy=%b done=%b dout=%h want 0/1/5a", busy, done, dout);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    clr = 1'b0; en = 1'b0; mode = 3'b000; din = '0;
    sr_ser = 1'b0; sl_ser = 1'b0; start = 1'b0; amt = '0;
    #2;
    test_reset();
    test_single_step();
    test_rotate_seq();
    test_asr_shl();
    test_abort();
    test_degenerate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
